relobi_addr_map_cfg: RTL and testbench
======================================

RELOBI_ADDR_MAP_CFG -- requirements
Module: relobi_addr_map_cfg

Interface
REQ-001 SHALL have parameter NumAddrRules, default 4, giving the number of address rules held.
REQ-002 SHALL have parameter AddrWidth, default 32, giving the width of the rule start and end addresses.
REQ-003 SHALL have parameter IdxWidth, default 2, giving the width of the manager-port index per rule.
REQ-004 SHALL have parameter ScrubInterval, default 256, giving the idle cycles between scrub passes (minimum 1).
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 cfg_req_i  in  1  config access request.
REQ-008 cfg_we_i  in  1  1 = write, 0 = read.
REQ-009 cfg_addr_i  in  $clog2(NumAddrRules)+2  {rule, field}; field 0 = idx, 1 = start, 2 = end, 3 = invalid.
REQ-010 cfg_wdata_i  in  AddrWidth  write data (idx uses the low IdxWidth bits).
REQ-011 cfg_gnt_o  out  1  access accepted.
REQ-012 cfg_rvalid_o / cfg_rdata_o / cfg_err_o  out  1/AddrWidth/1  read response, voted data, invalid-field flag.
REQ-013 map_idx_o / map_start_o / map_end_o  out  [3][NumAddrRules] x IdxWidth/AddrWidth/AddrWidth  three independent map copies driving the TMR address decoders.
REQ-014 corr_cnt_o  out  16  count of repaired fields, saturating.
REQ-015 uncorr_o  out  1  sticky flag: all three copies disagreed.
REQ-016 clr_i  in  1  clears corr_cnt_o and uncorr_o.

Function
REQ-017 SHALL grant every request in the same cycle: cfg_gnt_o = cfg_req_i.
REQ-018 SHALL write cfg_wdata_i into all three copies of the addressed field on the granted write edge; outputs update the next cycle.
REQ-019 SHALL return the bitwise 2-of-3 majority of the addressed field, with cfg_rvalid_o high exactly one cycle after every granted access (reads and writes); cfg_rdata_o SHALL be 0 for writes.
REQ-020 SHALL, for field 3, ignore the write, return rdata 0 and assert cfg_err_o with rvalid.
REQ-021 Scrubber FSM states: IDLE, CHECK, REPAIR.
- IDLE counts down ScrubInterval cycles, then goes to CHECK with pointer = rule 0, field 0.
REQ-022 CHECK SHALL compare the three copies of the pointed field in one cycle.
- Equal: advance the pointer and stay in CHECK; after rule NumAddrRules-1, field 2, wrap to 0 and return to IDLE.
- Mismatch: go to REPAIR.
REQ-023 REPAIR SHALL recompute the majority and write it to all three copies.
- It increments corr_cnt_o (saturating at 0xFFFF), advances the pointer and returns to CHECK.
- If all three copies differ pairwise, it writes nothing, sets uncorr_o and advances.
REQ-024 A granted cfg access SHALL stall the scrubber that cycle: no state change, no repair write.
- A cfg write therefore always wins over a repair to the same field.
REQ-025 clr_i SHALL take effect the next edge; clr_i coincident with a repair SHALL leave corr_cnt_o = 0.
REQ-026 All outputs SHALL be registered except cfg_gnt_o.

Reset
REQ-027 rst_i SHALL zero all map copies, corr_cnt_o, uncorr_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o and the scrub pointer, and set the FSM to IDLE with the counter reloaded.
REQ-028 rst_i SHALL abort any in-flight scrub or read response; an access presented in the reset cycle SHALL be dropped.

Configuration
REQ-029 With RELOBI_MAP_SCRUB_EN defined, the scrubber FSM and its counters SHALL be present.
REQ-030 Without RELOBI_MAP_SCRUB_EN, the scrubber SHALL be absent, corr_cnt_o and uncorr_o SHALL be tied 0, and the cfg path SHALL be unchanged.

Verification
REQ-031 Write rule 1 start = 0x1000_0000 then read it -> rvalid next cycle, rdata 0x1000_0000, all three map_start_o[*][1] equal.
REQ-032 Force copy 2 of rule 0 end to 0xDEAD, ScrubInterval=4 -> within 4+4 cycles all copies restored to 0 and corr_cnt_o = 1.
REQ-033 Force three distinct values in rule 2 idx -> uncorr_o = 1 and corr_cnt_o unchanged; then clr_i -> uncorr_o = 0.
REQ-034 Continuous cfg reads during a pending repair -> scrubber stalls; repair completes the cycle after cfg_req_i drops.
REQ-035 Access with field 3 -> cfg_err_o = 1, rdata 0, map unchanged.
REQ-036 Assert rst_i while in REPAIR -> next cycle the FSM is IDLE, all copies are 0 and corr_cnt_o = 0.

Source files
------------

// File: rtl/relobi_addr_map_cfg.sv
`timescale 1ns/1ps
// relobi_addr_map_cfg
//
// Triple-redundant address map for the TMR address decoders. Each rule has an
// index, a start address and an end address. Three independent copies of each
// field drive the three decoders. A single-cycle config port writes all three
// copies at once. Reads return the bitwise 2-of-3 majority of the three copies.
//
// The scrubber is optional and is present only when RELOBI_MAP_SCRUB_EN is
// defined. It walks every field after each idle interval. When the copies
// disagree it repairs them from the majority. When all three copies differ it
// cannot repair them, so it raises a sticky flag instead.
//
// Ports
//   clk_i, rst_i            clock and synchronous active-high reset
//   cfg_req_i, cfg_we_i     access request and direction (1 = write)
//   cfg_addr_i              {rule, field}; field 0 idx, 1 start, 2 end, 3 invalid
//   cfg_wdata_i             write data (idx takes the low IdxWidth bits)
//   cfg_gnt_o               grant, combinationally equal to cfg_req_i
//   cfg_rvalid_o            response, one cycle after every granted access
//   cfg_rdata_o             voted read data (0 for writes and invalid field)
//   cfg_err_o               invalid-field flag, qualified by cfg_rvalid_o
//   map_idx_o/start_o/end_o three map copies, [copy][rule]
//   corr_cnt_o              saturating count of repaired fields
//   uncorr_o                sticky: a field had three distinct copies
//   clr_i                   clears corr_cnt_o and uncorr_o
module relobi_addr_map_cfg #(
    parameter int unsigned NumAddrRules  = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned IdxWidth      = 2,
    parameter int unsigned ScrubInterval = 256
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            cfg_req_i,
    input  logic                                            cfg_we_i,
    input  logic [$clog2(NumAddrRules)+1:0]                 cfg_addr_i,
    input  logic [AddrWidth-1:0]                            cfg_wdata_i,
    output logic                                            cfg_gnt_o,
    output logic                                            cfg_rvalid_o,
    output logic [AddrWidth-1:0]                            cfg_rdata_o,
    output logic                                            cfg_err_o,
    output logic [2:0][NumAddrRules-1:0][IdxWidth-1:0]      map_idx_o,
    output logic [2:0][NumAddrRules-1:0][AddrWidth-1:0]     map_start_o,
    output logic [2:0][NumAddrRules-1:0][AddrWidth-1:0]     map_end_o,
    output logic [15:0]                                     corr_cnt_o,
    output logic                                            uncorr_o,
    input  logic                                            clr_i
);

    localparam int unsigned    RuleW      = $clog2(NumAddrRules);
    localparam logic [RuleW:0] RuleCount  = (RuleW+1)'(NumAddrRules);
    localparam logic [1:0]     FieldIdx   = 2'd0;
    localparam logic [1:0]     FieldStart = 2'd1;
    localparam logic [1:0]     FieldEnd   = 2'd2;
    localparam logic [1:0]     FieldInv   = 2'd3;

    function automatic logic [AddrWidth-1:0] maj3(input logic [AddrWidth-1:0] a,
                                                  input logic [AddrWidth-1:0] b,
                                                  input logic [AddrWidth-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [2:0][NumAddrRules-1:0][IdxWidth-1:0]  idx_q;
    logic [2:0][NumAddrRules-1:0][AddrWidth-1:0] start_q;
    logic [2:0][NumAddrRules-1:0][AddrWidth-1:0] end_q;

    logic [RuleW-1:0]          cfg_rule;
    logic [1:0]                cfg_field;
    logic                      cfg_rule_ok;
    logic                      cfg_wr;
    logic [2:0][AddrWidth-1:0] cfg_copy;

    assign {cfg_rule, cfg_field} = cfg_addr_i;
    // The widened compare stays meaningful when NumAddrRules is not a power of two.
    assign cfg_rule_ok = {1'b0, cfg_rule} < RuleCount;
    assign cfg_wr      = cfg_req_i && cfg_we_i && (cfg_field != FieldInv) && cfg_rule_ok;
    assign cfg_gnt_o   = cfg_req_i;

    // Fetch the three copies of the addressed field, widened to AddrWidth.
    always_comb begin
        // NOTE: every branch starts from a default, so no latch can be inferred.
        cfg_copy = '0;
        if (cfg_rule_ok) begin
            for (int c = 0; c < 3; c++) begin
                case (cfg_field)
                    FieldIdx:   cfg_copy[c] = AddrWidth'(idx_q[c][cfg_rule]);
                    FieldStart: cfg_copy[c] = start_q[c][cfg_rule];
                    FieldEnd:   cfg_copy[c] = end_q[c][cfg_rule];
                    default:    cfg_copy[c] = '0;
                endcase
            end
        end
    end

`ifdef RELOBI_MAP_SCRUB_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPAIR = 2'd2
    } scrub_state_e;

    localparam int unsigned     CntW      = $clog2(ScrubInterval) + 1;
    localparam logic [CntW-1:0] CntReload = CntW'(ScrubInterval - 1);

    scrub_state_e              state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [RuleW-1:0]          ptr_rule_q, ptr_rule_d, ptr_rule_nxt;
    logic [1:0]                ptr_field_q, ptr_field_d, ptr_field_nxt;
    logic                      ptr_last;
    logic [2:0][AddrWidth-1:0] scr_copy;
    logic [AddrWidth-1:0]      scr_maj;
    logic                      scr_equal, scr_all_diff;
    logic                      repair_we, corr_inc, uncorr_set;
    logic [15:0]               corr_cnt_q;
    logic                      uncorr_q;

    always_comb begin
        scr_copy = '0;
        for (int c = 0; c < 3; c++) begin
            case (ptr_field_q)
                FieldIdx:   scr_copy[c] = AddrWidth'(idx_q[c][ptr_rule_q]);
                FieldStart: scr_copy[c] = start_q[c][ptr_rule_q];
                FieldEnd:   scr_copy[c] = end_q[c][ptr_rule_q];
                default:    scr_copy[c] = '0;
            endcase
        end
    end

    assign scr_maj      = maj3(scr_copy[0], scr_copy[1], scr_copy[2]);
    assign scr_equal    = (scr_copy[0] == scr_copy[1]) && (scr_copy[1] == scr_copy[2]);
    assign scr_all_diff = (scr_copy[0] != scr_copy[1]) && (scr_copy[1] != scr_copy[2]) &&
                          (scr_copy[0] != scr_copy[2]);

    assign ptr_last      = (ptr_rule_q == RuleW'(NumAddrRules - 1)) && (ptr_field_q == FieldEnd);
    assign ptr_field_nxt = (ptr_field_q == FieldEnd) ? FieldIdx : ptr_field_q + 2'd1;
    assign ptr_rule_nxt  = (ptr_field_q != FieldEnd) ? ptr_rule_q :
                           ptr_last ? '0 : ptr_rule_q + RuleW'(1);

    // A granted cfg access freezes the scrubber for that cycle. As a result, a
    // cfg write to a field always wins over a repair of the same field.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_rule_d  = ptr_rule_q;
        ptr_field_d = ptr_field_q;
        repair_we   = 1'b0;
        corr_inc    = 1'b0;
        uncorr_set  = 1'b0;
        if (!cfg_req_i) begin
            case (state_q)
                IDLE: begin
                    if (cnt_q == '0) begin
                        state_d     = CHECK;
                        cnt_d       = CntReload;
                        ptr_rule_d  = '0;
                        ptr_field_d = FieldIdx;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                CHECK: begin
                    if (!scr_equal) begin
                        state_d = REPAIR;
                    end else begin
                        ptr_rule_d  = ptr_rule_nxt;
                        ptr_field_d = ptr_field_nxt;
                        state_d     = ptr_last ? IDLE : CHECK;
                    end
                end
                REPAIR: begin
                    // Re-evaluate here: a stalling cfg write may already have
                    // made the copies agree again.
                    if (scr_all_diff) begin
                        uncorr_set = 1'b1;
                    end else if (!scr_equal) begin
                        repair_we = 1'b1;
                        corr_inc  = 1'b1;
                    end
                    ptr_rule_d  = ptr_rule_nxt;
                    ptr_field_d = ptr_field_nxt;
                    state_d     = ptr_last ? IDLE : CHECK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= CntReload;
            ptr_rule_q  <= '0;
            ptr_field_q <= FieldIdx;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_rule_q  <= ptr_rule_d;
            ptr_field_q <= ptr_field_d;
        end
    end

    // Clearing takes priority over a coincident repair or uncorrectable event.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            corr_cnt_q <= '0;
            uncorr_q   <= 1'b0;
        end else begin
            if (corr_inc && corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
            if (uncorr_set) uncorr_q <= 1'b1;
        end
    end

    assign corr_cnt_o = corr_cnt_q;
    assign uncorr_o   = uncorr_q;
`else
    logic unused_clr;
    localparam int unsigned unused_scrub_interval = ScrubInterval;
    assign unused_clr = clr_i;
    assign corr_cnt_o = '0;
    assign uncorr_o   = 1'b0;
`endif

    // Map copies are plain flops that feed the decoders directly. They must
    // therefore come out of reset holding a defined, consistent value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: this map lives in flops rather than RAM. Resetting every entry
            // is intended and cheap here.
            idx_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
        end else if (cfg_wr) begin
            for (int c = 0; c < 3; c++) begin
                case (cfg_field)
                    FieldIdx:   idx_q[c][cfg_rule]   <= cfg_wdata_i[IdxWidth-1:0];
                    FieldStart: start_q[c][cfg_rule] <= cfg_wdata_i;
                    FieldEnd:   end_q[c][cfg_rule]   <= cfg_wdata_i;
                    default:    ;
                endcase
            end
`ifdef RELOBI_MAP_SCRUB_EN
        end else if (repair_we) begin
            for (int c = 0; c < 3; c++) begin
                case (ptr_field_q)
                    FieldIdx:   idx_q[c][ptr_rule_q]   <= scr_maj[IdxWidth-1:0];
                    FieldStart: start_q[c][ptr_rule_q] <= scr_maj;
                    FieldEnd:   end_q[c][ptr_rule_q]   <= scr_maj;
                    default:    ;
                endcase
            end
`endif
        end
    end

    // A response register loaded on every edge. Reset clears it, so an access
    // presented during reset produces no response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: state is updated with non-blocking assignments only. This keeps
            // the evaluation order of the always_ff blocks from mattering.
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && (cfg_field == FieldInv);
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && cfg_field != FieldInv)
                            ? maj3(cfg_copy[0], cfg_copy[1], cfg_copy[2]) : '0;
        end
    end

    assign map_idx_o   = idx_q;
    assign map_start_o = start_q;
    assign map_end_o   = end_q;

endmodule

// File: tb/tb_relobi_addr_map_cfg.sv
`timescale 1ns/1ps
// Scoreboard bench for relobi_addr_map_cfg. The driver pushes the expected
// response of each access. A negedge monitor pops and compares each response.
// The reference map is a single array per field, since all copies should agree.
module tb_relobi_addr_map_cfg;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int IW  = 2;
    localparam int SI  = 4;
    localparam int CAW = $clog2(N) + 2;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          cfg_req = 1'b0;
    logic                          cfg_we = 1'b0;
    logic [CAW-1:0]                cfg_addr = '0;
    logic [AW-1:0]                 cfg_wdata = '0;
    logic                          cfg_gnt;
    logic                          cfg_rvalid;
    logic [AW-1:0]                 cfg_rdata;
    logic                          cfg_err;
    logic [2:0][N-1:0][IW-1:0]     map_idx;
    logic [2:0][N-1:0][AW-1:0]     map_start;
    logic [2:0][N-1:0][AW-1:0]     map_end;
    logic [15:0]                   corr_cnt;
    logic                          uncorr;
    logic                          clr = 1'b0;

    relobi_addr_map_cfg #(
        .NumAddrRules (N),
        .AddrWidth    (AW),
        .IdxWidth     (IW),
        .ScrubInterval(SI)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_req_i   (cfg_req),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_gnt_o   (cfg_gnt),
        .cfg_rvalid_o(cfg_rvalid),
        .cfg_rdata_o (cfg_rdata),
        .cfg_err_o   (cfg_err),
        .map_idx_o   (map_idx),
        .map_start_o (map_start),
        .map_end_o   (map_end),
        .corr_cnt_o  (corr_cnt),
        .uncorr_o    (uncorr),
        .clr_i       (clr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference map: one value per field.
    logic [IW-1:0] m_idx   [N];
    logic [AW-1:0] m_start [N];
    logic [AW-1:0] m_end   [N];

    typedef struct {
        int unsigned   cyc;
        logic [AW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    function automatic logic [AW-1:0] model_read(input int r, input int f);
        case (f)
            0:       return AW'(m_idx[r]);
            1:       return m_start[r];
            2:       return m_end[r];
            default: return '0;
        endcase
    endfunction

    task automatic model_clear();
        for (int r = 0; r < N; r++) begin
            m_idx[r]   = '0;
            m_start[r] = '0;
            m_end[r]   = '0;
        end
    endtask

    // Presents one access for one clock edge and leaves cfg_req asserted.
    task automatic do_op(input logic we, input int r, input int f, input logic [AW-1:0] wd);
        exp_t e;
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = {r[CAW-3:0], f[1:0]};
        cfg_wdata = wd;
        e.cyc   = cyc + 1;
        e.err   = (f == 3);
        e.rdata = (we || f == 3) ? '0 : model_read(r, f);
        exp_q.push_back(e);
        if (we) begin
            case (f)
                0:       m_idx[r]   = wd[IW-1:0];
                1:       m_start[r] = wd;
                2:       m_end[r]   = wd;
                default: ;
            endcase
        end
        #1 check("gnt_high", 32'(cfg_gnt), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        #1 check("gnt_low", 32'(cfg_gnt), 32'd0);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_map(input string tag);
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < N; r++) begin
                check({tag, "_idx"},   32'(map_idx[c][r]), 32'(m_idx[r]));
                check({tag, "_start"}, map_start[c][r],    m_start[r]);
                check({tag, "_end"},   map_end[c][r],      m_end[r]);
            end
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (cfg_rvalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: rvalid with no access outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("rsp_rdata", cfg_rdata, mon_e.rdata);
                check("rsp_err",   32'(cfg_err), 32'(mon_e.err));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL rsp_missing: rvalid 0, response due at cycle %0d (now %0d)", mon_e.cyc, cyc);
        end
    end

`ifdef RELOBI_MAP_SCRUB_EN
    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (32'(dut.state_q) != 32'(s) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(dut.state_q), 32'(s));
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        int          n;
        model_clear();

        // Reset. The write presented during the last reset cycle must be dropped.
        repeat (3) @(posedge clk);
        #1;
        cfg_req   = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = {2'd0, 2'd1};
        cfg_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        rst     = 1'b0;
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        check("rst_rvalid", 32'(cfg_rvalid), 32'd0);
        check("rst_rdata",  cfg_rdata, 32'd0);
        check("rst_err",    32'(cfg_err), 32'd0);
        check("rst_corr",   32'(corr_cnt), 32'd0);
        check("rst_uncorr", 32'(uncorr), 32'd0);
        check_map("rst_map");
        idle(1);

        // Write rule 1 start, then read it back.
        do_op(1'b1, 1, 1, 32'h1000_0000);
        do_op(1'b0, 1, 1, 32'h0);
        idle(1);
        check_map("wr_rd_map");

        // The index field keeps only its low bits. Then read it back immediately.
        do_op(1'b1, 0, 0, 32'hFFFF_FFFD);
        do_op(1'b0, 0, 0, 32'h0);
        // All-ones and all-zeros boundaries, with back-to-back write and read.
        do_op(1'b1, N-1, 2, 32'hFFFF_FFFF);
        do_op(1'b0, N-1, 2, 32'h0);
        do_op(1'b1, N-1, 2, 32'h0);
        do_op(1'b0, N-1, 2, 32'h0);
        // An access to field 3 is flagged as an error and changes nothing.
        do_op(1'b1, 2, 3, 32'hFFFF_FFFF);
        do_op(1'b0, 2, 3, 32'h0);
        idle(2);
        check_map("inv_map");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1 + int'($urandom_range(0, 2)));
            end else begin
                do_op(1'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
                      int'($urandom_range(0, 3)), $urandom());
            end
            if (i % 75 == 74) begin
                idle(1);
                check_map("rand_map");
            end
        end
        idle(2);
        check("traffic_corr",   32'(corr_cnt), 32'd0);
        check("traffic_uncorr", 32'(uncorr), 32'd0);

`ifdef RELOBI_MAP_SCRUB_EN
        // A single corrupted copy is voted out and repaired.
        do_op(1'b1, 0, 2, 32'h0);
        idle(1);
        @(negedge clk);
        base = corr_cnt;
        dut.end_q[2][0] = 32'hDEAD;
        n = 0;
        while (map_end[2][0] != m_end[0] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("scrub_restore", map_end[2][0], m_end[0]);
        check("scrub_corr",    32'(corr_cnt), 32'(base + 16'd1));
        check_map("scrub_map");

        // Three distinct copies cannot be repaired. They are flagged and left as they are.
        do_op(1'b1, 2, 0, 32'h0);
        idle(1);
        @(negedge clk);
        base = corr_cnt;
        dut.idx_q[0][2] = 2'd0;
        dut.idx_q[1][2] = 2'd1;
        dut.idx_q[2][2] = 2'd2;
        n = 0;
        while (uncorr !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("uncorr_set",   32'(uncorr), 32'd1);
        check("uncorr_corr",  32'(corr_cnt), 32'(base));
        check("uncorr_copy1", 32'(map_idx[1][2]), 32'd1);
        check("uncorr_copy2", 32'(map_idx[2][2]), 32'd2);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_uncorr", 32'(uncorr), 32'd0);
        check("clr_corr",   32'(corr_cnt), 32'd0);
        do_op(1'b1, 2, 0, 32'h3);
        idle(1);
        check_map("uncorr_fix_map");

        // Continuous reads stall a pending repair. The read still returns the voted value.
        do_op(1'b1, 3, 1, 32'h3000_0000);
        idle(1);
        @(negedge clk);
        base = corr_cnt;
        dut.start_q[1][3] = 32'hDEAD;
        wait_state(2, 60, "stall_reach_repair");
        for (int i = 0; i < 8; i++) do_op(1'b0, 3, 1, 32'h0);
        check("stall_state", 32'(dut.state_q), 32'd2);
        check("stall_copy",  map_start[1][3], 32'hDEAD);
        cfg_req = 1'b0;
        @(posedge clk); #1;
        check("stall_repaired", map_start[1][3], m_start[3]);
        check("stall_corr",     32'(corr_cnt), 32'(base + 16'd1));

        // When clear coincides with a repair, the counter is left at 0.
        @(negedge clk);
        dut.end_q[0][1] = ~m_end[1];
        wait_state(2, 60, "clr_reach_repair");
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_repair_corr", 32'(corr_cnt), 32'd0);
        check("clr_repair_copy", map_end[0][1], m_end[1]);

        // A reset during REPAIR aborts the repair and clears everything.
        @(negedge clk);
        dut.idx_q[2][0] = ~m_idx[0];
        wait_state(2, 60, "rst_reach_repair");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        check("rst_repair_state", 32'(dut.state_q), 32'd0);
        check("rst_repair_corr",  32'(corr_cnt), 32'd0);
        check_map("rst_repair_map");
`endif

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
